// File: rtl/bank_scan_controller_if.sv
// rtl/bank_scan_controller_if.sv - detector and payload stream signals of the bank scan controller
//
// Purpose: bundles the detector handshake (det_*) and the payload stream
// (out_*) so the controller and its environment connect through one port.
// Ports (master = controller side):
//   det_dat  in   decoded bit from detector
//   det_vld  in   qualifies det_dat, one cycle per bit
//   det_rst  out  detector reset; detector loads det_bank while high
//   det_bank out  bank select to detector, BW bits
//   out_dat  out  payload bit after preamble lock
//   out_vld  out  qualifies out_dat
interface bank_scan_controller_if #(
  parameter int BW = 2
);
  logic          det_dat;
  logic          det_vld;
  logic          det_rst;
  logic [BW-1:0] det_bank;
  logic          out_dat;
  logic          out_vld;

  modport master (
    input  det_dat, det_vld,
    output det_rst, det_bank, out_dat, out_vld
  );

  modport slave (
    output det_dat, det_vld,
    input  det_rst, det_bank, out_dat, out_vld
  );
endinterface

// File: rtl/bank_scan_controller.sv
// rtl/bank_scan_controller.sv - scans detector banks for a preamble and forwards the payload
//
// Purpose: steps the detector through BANKS frequency banks, giving each
// bank TIMEOUT cycles to deliver PREAMBLE; on a match it locks and forwards
// every following detector bit, otherwise it ends in FAIL.
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   pulse; begins a scan from bank 0 (IDLE or FAIL only)
//   stop    in   pulse; aborts any activity and returns to IDLE
//   bus     master modport of bank_scan_controller_if (det_* / out_*)
//   locked  out  high in LOCKED
//   fail    out  high in FAIL
//   busy    out  high in ARM or SEARCH
module bank_scan_controller #(
  parameter int                 BANKS    = 4,
  parameter int                 PRE_LEN  = 6,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 6'b101100,
  parameter int                 TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  bank_scan_controller_if.master    bus,
  output logic                      locked,
  output logic                      fail,
  output logic                      busy
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(PRE_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SEARCH,
    LOCKED,
    FAIL
  } state_t;

  state_t               state_q, state_n;
  logic [BW-1:0]        bank_q, bank_n;
  logic [TW-1:0]        timer_q, timer_n;
  logic [PRE_LEN-1:0]   shift_q, shift_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic                 out_dat_n, out_vld_n;
  logic                 match;

  // Match is judged on the bit arriving now, so the lock decision does not
  // wait for the bit to land in the shift register.
  assign match = bus.det_vld
              && (cnt_q >= CW'(PRE_LEN - 1))
              && ({shift_q[PRE_LEN-2:0], bus.det_dat} == PREAMBLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= '0;
      timer_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      bank_q  <= bank_n;
      timer_q <= timer_n;
      shift_q <= shift_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    bank_n    = bank_q;
    timer_n   = timer_q;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    out_vld_n = 1'b0;
    out_dat_n = bus.out_dat;

    unique case (state_q)
      IDLE, FAIL: begin
        if (start) begin
          state_n = ARM;
          bank_n  = '0;
        end
      end

      ARM: begin
        state_n = SEARCH;
        timer_n = '0;
        shift_n = '0;
        cnt_n   = '0;
      end

      SEARCH: begin
        timer_n = timer_q + TW'(1);
        if (bus.det_vld) begin
          shift_n = {shift_q[PRE_LEN-2:0], bus.det_dat};
          if (cnt_q != CW'(PRE_LEN)) begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        // A match wins over a timeout landing on the same cycle.
        if (match) begin
          state_n = LOCKED;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          if (int'(bank_q) < BANKS - 1) begin
            state_n = ARM;
            bank_n  = bank_q + BW'(1);
          end else begin
            state_n = FAIL;
          end
        end
      end

      LOCKED: begin
        if (bus.det_vld) begin
          out_vld_n = 1'b1;
          out_dat_n = bus.det_dat;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (stop) begin
      state_n   = IDLE;
      bank_n    = '0;
      out_vld_n = 1'b0;
    end
  end

  // Outputs are registered from the next-state view so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.det_rst  <= 1'b1;
      bus.det_bank <= '0;
      bus.out_dat  <= 1'b0;
      bus.out_vld  <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bus.det_rst  <= (state_n == IDLE) || (state_n == ARM) || (state_n == FAIL);
      bus.det_bank <= bank_n;
      bus.out_dat  <= out_dat_n;
      bus.out_vld  <= out_vld_n;
      locked       <= (state_n == LOCKED);
      fail         <= (state_n == FAIL);
      busy         <= (state_n == ARM) || (state_n == SEARCH);
    end
  end

endmodule

// File: tb/tb_bank_scan_controller.sv
// tb/tb_bank_scan_controller.sv - directed self-checking bench for bank_scan_controller
module tb_bank_scan_controller;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic locked;
  logic fail;
  logic busy;

  int checks;
  int errors;

  logic [5:0] pre;
  logic [6:0] off;

  bank_scan_controller_if #(.BW(2)) bus ();

  bank_scan_controller #(
    .BANKS    (4),
    .PRE_LEN  (6),
    .PREAMBLE (6'b101100),
    .TIMEOUT  (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .bus    (bus),
    .locked (locked),
    .fail   (fail),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, settle 1ns after.
  task automatic cyc(input logic s, input logic p, input logic v, input logic d);
    start       = s;
    stop        = p;
    bus.det_vld = v;
    bus.det_dat = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pre         = 6'b101100;
    off         = 7'b0101100;
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    bus.det_vld = 1'b0;
    bus.det_dat = 1'b0;

    // Reset values
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk("rst_det_rst", bus.det_rst, 1);
    chk("rst_det_bank", bus.det_bank, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_dat", bus.out_dat, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("idle_det_rst", bus.det_rst, 1);
    chk("idle_busy", busy, 0);

    // Basic lock on bank 0 and payload forwarding
    cyc(1, 0, 0, 0);
    chk("arm_busy", busy, 1);
    chk("arm_det_rst", bus.det_rst, 1);
    chk("arm_bank", bus.det_bank, 0);
    cyc(0, 0, 0, 0);
    chk("search_det_rst", bus.det_rst, 0);
    for (int i = 5; i >= 1; i--) begin
      cyc((i == 5), 0, 1, pre[i]);
      chk("pre_no_lock", locked, 0);
      chk("pre_no_out", bus.out_vld, 0);
      chk("pre_start_ignored", bus.det_rst, 0);
    end
    cyc(0, 0, 1, pre[0]);
    chk("lock_locked", locked, 1);
    chk("lock_busy", busy, 0);
    chk("lock_bank", bus.det_bank, 0);
    chk("lock_no_out", bus.out_vld, 0);
    cyc(0, 0, 1, 1);
    chk("pay1_vld", bus.out_vld, 1);
    chk("pay1_dat", bus.out_dat, 1);
    cyc(0, 0, 0, 0);
    chk("pay_gap_vld", bus.out_vld, 0);
    cyc(0, 0, 1, 0);
    chk("pay2_vld", bus.out_vld, 1);
    chk("pay2_dat", bus.out_dat, 0);
    cyc(0, 1, 0, 0);
    chk("stop_locked", locked, 0);
    chk("stop_det_rst", bus.det_rst, 1);
    chk("stop_out_vld", bus.out_vld, 0);

    // Timeouts walk every bank, then FAIL
    cyc(1, 0, 0, 0);
    chk("to_arm_bank", bus.det_bank, 0);
    chk("to_arm_det_rst", bus.det_rst, 1);
    for (int b = 0; b < 4; b++) begin
      cyc(0, 0, 0, 0);
      chk("to_search_det_rst", bus.det_rst, 0);
      chk("to_search_bank", bus.det_bank, b);
      chk("to_search_busy", busy, 1);
      repeat (63) cyc(0, 0, 0, 0);
      chk("to_last_search", bus.det_rst, 0);
      cyc(0, 0, 0, 0);
      if (b < 3) begin
        chk("to_step_det_rst", bus.det_rst, 1);
        chk("to_step_bank", bus.det_bank, b + 1);
        chk("to_step_busy", busy, 1);
      end else begin
        chk("to_fail", fail, 1);
        chk("to_fail_busy", busy, 0);
        chk("to_fail_det_rst", bus.det_rst, 1);
        chk("to_fail_bank", bus.det_bank, 3);
      end
    end
    cyc(1, 0, 0, 0);
    chk("fail_restart_bank", bus.det_bank, 0);
    chk("fail_restart_fail", fail, 0);
    chk("fail_restart_busy", busy, 1);
    cyc(0, 1, 0, 0);

    // Preamble offset by one bit
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 6; i >= 1; i--) begin
      cyc(0, 0, 1, off[i]);
      chk("off_no_lock", locked, 0);
      chk("off_no_out", bus.out_vld, 0);
    end
    cyc(0, 0, 1, off[0]);
    chk("off_lock", locked, 1);
    chk("off_no_out7", bus.out_vld, 0);
    cyc(0, 1, 0, 0);

    // Final preamble bit on the last timer cycle
    cyc(1, 0, 0, 0);
    repeat (59) cyc(0, 0, 0, 0);
    for (int i = 5; i >= 1; i--) cyc(0, 0, 1, pre[i]);
    chk("edge_pre_lock", locked, 0);
    cyc(0, 0, 1, pre[0]);
    chk("edge_locked", locked, 1);
    chk("edge_bank", bus.det_bank, 0);
    chk("edge_det_rst", bus.det_rst, 0);
    chk("edge_busy", busy, 0);
    cyc(0, 1, 0, 0);

    // stop beats a match on bank 2
    cyc(1, 0, 0, 0);
    repeat (130) cyc(0, 0, 0, 0);
    chk("stop_b2_bank", bus.det_bank, 2);
    chk("stop_b2_det_rst", bus.det_rst, 1);
    cyc(0, 0, 0, 0);
    for (int i = 5; i >= 1; i--) cyc(0, 0, 1, pre[i]);
    cyc(0, 1, 1, pre[0]);
    chk("stop_b2_locked", locked, 0);
    chk("stop_b2_idle_rst", bus.det_rst, 1);
    chk("stop_b2_busy", busy, 0);
    cyc(1, 0, 0, 0);
    chk("stop_b2_restart", bus.det_bank, 0);
    chk("stop_b2_restart_busy", busy, 1);

    // rst in LOCKED during det_vld
    cyc(0, 0, 0, 0);
    for (int i = 5; i >= 0; i--) cyc(0, 0, 1, pre[i]);
    chk("rl_locked", locked, 1);
    rst = 1'b1;
    cyc(1, 1, 1, 1);
    chk("rl_out_vld", bus.out_vld, 0);
    chk("rl_out_dat", bus.out_dat, 0);
    chk("rl_locked0", locked, 0);
    chk("rl_det_rst", bus.det_rst, 1);
    chk("rl_bank", bus.det_bank, 0);
    chk("rl_busy", busy, 0);
    chk("rl_fail", fail, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_scan_controller.md
BANK_SCAN_CONTROLLER -- requirements
Module: bank_scan_controller

Interface
REQ-001 SHALL have parameter BANKS, default 4: number of detector frequency banks scanned.
REQ-002 SHALL have parameter PRE_LEN, default 6: preamble length in bits.
REQ-003 SHALL have parameter PREAMBLE, default 6'b101100: expected preamble, first received bit in MSB.
REQ-004 SHALL have parameter TIMEOUT, default 64: clk cycles allowed per bank before advancing.
REQ-005 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have start  input  1  pulse; begins a scan from bank 0.
REQ-008 SHALL have stop  input  1  pulse; aborts any activity and returns to idle.
REQ-009 SHALL have det_dat  input  1  decoded bit from detector.
REQ-010 SHALL have det_vld  input  1  qualifies det_dat, one cycle per bit.
REQ-011 SHALL have det_rst  output  1  reset to detector; detector loads det_bank while high.
REQ-012 SHALL have det_bank  output  BW  bank select to detector; BW = max(1, clog2(BANKS)).
REQ-013 SHALL have out_dat  output  1  payload bit after preamble lock.
REQ-014 SHALL have out_vld  output  1  qualifies out_dat.
REQ-015 SHALL have locked  output  1  high in LOCKED state.
REQ-016 SHALL have fail  output  1  high in FAIL state.
REQ-017 SHALL have busy  output  1  high in ARM or SEARCH.

Function
REQ-018 SHALL implement states IDLE, ARM, SEARCH, LOCKED, FAIL; all outputs registered.
REQ-019 IDLE: det_rst=1; start -> ARM with bank=0.
REQ-020 ARM: lasts exactly one cycle; det_rst=1, det_bank=bank; clears shift register, bit count, timer; -> SEARCH.
REQ-021 SEARCH: det_rst=0; timer increments every cycle; on det_vld shift det_dat into LSB of PRE_LEN-bit shift register; bit count saturates at PRE_LEN.
REQ-022 Match SHALL be evaluated on the incoming bit: det_vld=1, bit count >= PRE_LEN-1, and {shift[PRE_LEN-2:0], det_dat} == PREAMBLE -> LOCKED next cycle.
REQ-023 Timeout: timer == TIMEOUT-1 without match -> ARM with bank+1 if bank < BANKS-1, else FAIL.
REQ-024 Match and timeout in the same cycle SHALL resolve to LOCKED.
REQ-025 LOCKED: det_rst=0, det_bank held; each det_vld produces out_vld=1, out_dat=det_dat one cycle later; preamble bits are never forwarded.
REQ-026 FAIL: det_rst=1; start -> ARM with bank=0.
REQ-027 stop SHALL move any state to IDLE next cycle and take priority over start, match and timeout; out_vld=0 from that cycle.
REQ-028 start SHALL be ignored in ARM, SEARCH, LOCKED.
REQ-029 Bank index SHALL never exceed BANKS-1 and SHALL not wrap.
REQ-030 Detector latency SHALL not be assumed; only det_vld qualifies data.

Reset
REQ-031 On rst: state IDLE, bank 0, det_bank 0, det_rst 1, out_dat 0, out_vld 0, locked 0, fail 0, busy 0, timer, shift register and bit count 0.
REQ-032 rst mid-operation SHALL take effect next edge, overriding all other inputs including stop and start.

Verification
REQ-033 start, bank 0 delivers bits 1,0,1,1,0,0 within 20 cycles -> locked=1 with det_bank=0; subsequent bits 1,0 -> out_vld pulses with out_dat 1,0, each one cycle after det_vld.
REQ-034 start, no det_vld for 64 cycles per bank -> det_bank steps 0,1,2,3 with a one-cycle det_rst pulse at each step; after bank 3 times out, fail=1, busy=0.
REQ-035 Bits 0,1,0,1,1,0,0 on bank 0 (preamble offset by one) -> lock on the 7th bit; no out_vld for any of the first 7 bits.
REQ-036 Final preamble bit arrives on timer=63 -> LOCKED, not ARM; det_bank unchanged.
REQ-037 stop asserted in SEARCH on bank 2 in the same cycle as a matching bit -> IDLE, locked=0, det_rst=1; a later start restarts at det_bank=0.
REQ-038 rst asserted in LOCKED during a det_vld -> next cycle all outputs at reset values and out_vld=0.
